// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi
//   Vending-machine controller with NUM_ITEMS priced products, capped credit
//   and coin-by-coin change return.
//
//   Ports
//     clk, reset        system clock, asynchronous active-high reset
//     coin_one/coin_ten level inputs, rising edge = coin inserted
//     buy[NUM_ITEMS]    level inputs, rising edge = purchase request
//     cancel, get_ind   level inputs, rising edge = refund / change request
//     op_start          session open (state != IDLE)
//     credit            current credit, binary
//     item_light        per item: enabled and affordable
//     vend_pulse        one-hot, one cycle, releases an item
//     not_enough        one-cycle pulse, buy refused for lack of credit
//     coin_reject       one-cycle pulse, coin would exceed MAX_CREDIT
//     change_ten/one    one pulse per returned coin
//     light_get         high throughout change return
//
//   Optional feature: define INACTIVITY_TIMEOUT_EN to auto-refund after
//   TIMEOUT_CYC idle cycles in CREDIT.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   S_IDLE   | no session, credit = 0
//   S_CREDIT | credit held, waiting for coins / buy / cancel
//   S_VEND   | single cycle, vend_pulse released for vend_idx_q
//   S_CHANGE | returning credit, one coin per cycle
module vend_ctrl_multi #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 99,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = 32'h0F_0A_08_05,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_one,
  input  logic                 coin_ten,
  input  logic [NUM_ITEMS-1:0] buy,
  input  logic                 cancel,
  input  logic                 get_ind,
  output logic                 op_start,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] item_light,
  output logic [NUM_ITEMS-1:0] vend_pulse,
  output logic                 not_enough,
  output logic                 coin_reject,
  output logic                 change_ten,
  output logic                 change_one,
  output logic                 light_get
);

  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [CREDIT_W-1:0] TEN = CREDIT_W'(10);
  localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [IDX_W-1:0]     vend_idx_q, vend_idx_d;
  logic                 not_enough_d, coin_reject_d;

  // Edge-detect history; armed_q blanks the first cycle after reset so that
  // inputs already high at release do not count as events.
  logic                 armed_q;
  logic                 coin_one_q, coin_ten_q, cancel_q, get_q;
  logic [NUM_ITEMS-1:0] buy_q;

  logic                 coin_one_ev, coin_ten_ev, cancel_ev, get_ev, coin_ev;
  logic [NUM_ITEMS-1:0] buy_ev;
  logic                 buy_hit;
  logic [IDX_W-1:0]     buy_idx;
  logic [CREDIT_W-1:0]  sel_price, coin_val;
  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_ok, any_ev, timeout_hit;

  logic [CREDIT_W-1:0]  price [NUM_ITEMS];

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
    assign price[g]      = PRICE_LIST[g*CREDIT_W +: CREDIT_W];
    assign item_light[g] = (price[g] != '0) && (credit_q >= price[g]);
  end

  assign coin_one_ev = armed_q & coin_one & ~coin_one_q;
  assign coin_ten_ev = armed_q & coin_ten & ~coin_ten_q;
  assign cancel_ev   = armed_q & cancel & ~cancel_q;
  assign get_ev      = armed_q & get_ind & ~get_q;
  assign buy_ev      = {NUM_ITEMS{armed_q}} & buy & ~buy_q;
  assign coin_ev     = coin_one_ev | coin_ten_ev;
  assign any_ev      = cancel_ev | get_ev | buy_hit | coin_ev;

  // Lowest set buy bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    buy_hit = 1'b0;
    buy_idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (buy_ev[i]) begin
        buy_hit = 1'b1;
        buy_idx = IDX_W'(i);
      end
    end
  end

  assign sel_price = price[buy_idx];
  assign coin_val  = coin_ten_ev ? TEN : CREDIT_W'(1);
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok   = (coin_sum <= MAX_EXT);

`ifdef INACTIVITY_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [TMR_W-1:0] timer_q, timer_d;

  // Down-counter reloaded outside CREDIT or on any event; terminal count
  // reached after TIMEOUT_CYC consecutive idle cycles in CREDIT.
  always_comb begin
    timer_d = timer_q;
    if (state_q != S_CREDIT || any_ev) timer_d = TMR_W'(TIMEOUT_CYC - 1);
    else if (timer_q != '0)            timer_d = timer_q - 1'b1;
  end

  assign timeout_hit = (state_q == S_CREDIT) && !any_ev && (timer_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= TMR_W'(TIMEOUT_CYC - 1);
    else       timer_q <= timer_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0) & any_ev;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_idx_d    = vend_idx_q;
    not_enough_d  = 1'b0;
    coin_reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel_ev || get_ev) begin
          if (state_q == S_CREDIT) state_d = S_CHANGE;
        end else if (buy_hit) begin
          if (sel_price != '0) begin
            if (credit_q >= sel_price) begin
              credit_d   = credit_q - sel_price;
              vend_idx_d = buy_idx;
              state_d    = S_VEND;
            end else begin
              not_enough_d = 1'b1;
            end
          end
        end else if (coin_ev) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_CHANGE;
        end
      end
      S_VEND: state_d = (credit_q == '0) ? S_IDLE : S_CREDIT;
      S_CHANGE: begin
        if (credit_q >= TEN)      credit_d = credit_q - TEN;
        else if (credit_q != '0)  credit_d = credit_q - 1'b1;
        if (credit_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      vend_idx_q  <= '0;
      not_enough  <= 1'b0;
      coin_reject <= 1'b0;
      armed_q     <= 1'b0;
      coin_one_q  <= 1'b0;
      coin_ten_q  <= 1'b0;
      cancel_q    <= 1'b0;
      get_q       <= 1'b0;
      buy_q       <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      vend_idx_q  <= vend_idx_d;
      not_enough  <= not_enough_d;
      coin_reject <= coin_reject_d;
      armed_q     <= 1'b1;
      coin_one_q  <= coin_one;
      coin_ten_q  <= coin_ten;
      cancel_q    <= cancel;
      get_q       <= get_ind;
      buy_q       <= buy;
    end
  end

  always_comb begin
    vend_pulse = '0;
    if (state_q == S_VEND) vend_pulse[vend_idx_q] = 1'b1;
  end

  assign credit     = credit_q;
  assign op_start   = (state_q != S_IDLE);
  assign light_get  = (state_q == S_CHANGE);
  assign change_ten = light_get && (credit_q >= TEN);
  assign change_one = light_get && (credit_q < TEN) && (credit_q != '0);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
module tb_vend_ctrl_multi;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         coin_one, coin_ten, cancel, get_ind;
  logic [N-1:0] buy;
  logic         op_start, not_enough, coin_reject, change_ten, change_one, light_get;
  logic [W-1:0] credit;
  logic [N-1:0] item_light, vend_pulse;

  vend_ctrl_multi #(
    .NUM_ITEMS(N), .CREDIT_W(W), .MAX_CREDIT(99),
    .PRICE_LIST(32'h0F_0A_08_05), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .reset(reset), .coin_one(coin_one), .coin_ten(coin_ten),
    .buy(buy), .cancel(cancel), .get_ind(get_ind), .op_start(op_start),
    .credit(credit), .item_light(item_light), .vend_pulse(vend_pulse),
    .not_enough(not_enough), .coin_reject(coin_reject),
    .change_ten(change_ten), .change_one(change_one), .light_get(light_get)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {vend_pulse[3:0], not_enough, coin_reject, change_ten, change_one}
  logic [7:0] exp_q[$];
  localparam logic [7:0] EV_NE = 8'b0000_1000;
  localparam logic [7:0] EV_CR = 8'b0000_0100;
  localparam logic [7:0] EV_CT = 8'b0000_0010;
  localparam logic [7:0] EV_CO = 8'b0000_0001;

  function automatic logic [7:0] ev_vend(input int i);
    logic [7:0] r;
    r = '0;
    r[4+i] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] e, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  logic [7:0] obs;
  logic [7:0] exp_e;
  always @(negedge clk) begin
    obs = {vend_pulse, not_enough, coin_reject, change_ten, change_one};
    if (!reset && obs != 8'h00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {24'h0, obs}, 32'h0);
      end else begin
        exp_e = exp_q.pop_front();
        check("pulse", {24'h0, obs}, {24'h0, exp_e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drive the given inputs high for one cycle, then low for one cycle.
  task automatic press(input logic c1, input logic c10, input logic [N-1:0] b,
                       input logic cn, input logic g);
    coin_one = c1; coin_ten = c10; buy = b; cancel = cn; get_ind = g;
    tick();
    coin_one = 0; coin_ten = 0; buy = '0; cancel = 0; get_ind = 0;
    tick();
  endtask

  task automatic ones(input int n);
    for (int k = 0; k < n; k++) press(1, 0, '0, 0, 0);
  endtask

  task automatic tens(input int n);
    for (int k = 0; k < n; k++) press(0, 1, '0, 0, 0);
  endtask

  initial begin
    reset = 1; coin_one = 1; coin_ten = 0; buy = '0; cancel = 0; get_ind = 0;
    ticks(2);
    check("rst_credit", credit, 0);
    check("rst_op_start", op_start, 0);
    check("rst_item_light", item_light, 0);
    check("rst_light_get", light_get, 0);
    // coin_one held high across reset release must not count as a coin
    reset = 0;
    ticks(3);
    check("held_input_credit", credit, 0);
    check("held_input_op_start", op_start, 0);
    coin_one = 0;
    tick();

    // 3 x one + ten = 13
    ones(3);
    tens(1);
    check("credit13", credit, 13);
    check("credit13_op_start", op_start, 1);
    check("credit13_lights", item_light, 4'b0111);

    push(ev_vend(1), 1);
    press(0, 0, 4'b0010, 0, 0);
    check("after_vend_credit", credit, 5);
    check("after_vend_lights", item_light, 4'b0001);

    push(EV_NE, 1);
    press(0, 0, 4'b1000, 0, 0);
    check("not_enough_credit", credit, 5);

    // change of 5: five change_one pulses, light_get for 5 cycles
    push(EV_CO, 5);
    press(0, 0, '0, 0, 1);
    check("change_light_on", light_get, 1);
    ticks(3);
    check("change_last_light", light_get, 1);
    check("change_last_credit", credit, 1);
    tick();
    check("change_done_light", light_get, 0);
    check("change_done_credit", credit, 0);
    check("change_done_op", op_start, 0);

    // buy in IDLE
    push(EV_NE, 1);
    press(0, 0, 4'b0001, 0, 0);
    check("idle_buy_credit", credit, 0);

    // 95, reject ten, cancel -> 9 tens then 5 ones
    tens(9);
    ones(5);
    check("credit95", credit, 95);
    push(EV_CR, 1);
    tens(1);
    check("reject_credit95", credit, 95);
    push(EV_CT, 9);
    push(EV_CO, 5);
    press(0, 0, '0, 1, 0);
    ticks(16);
    check("refund95_credit", credit, 0);

    // boundary: exactly 99 accepted, one more rejected
    tens(9);
    ones(9);
    check("credit99", credit, 99);
    check("credit99_lights", item_light, 4'b1111);
    push(EV_CR, 1);
    ones(1);
    check("reject_credit99", credit, 99);
    push(EV_CT, 9);
    push(EV_CO, 9);
    press(0, 0, '0, 1, 0);
    ticks(20);
    check("refund99_credit", credit, 0);

    // credit 8: cancel beats buy[0] in the same cycle
    ones(8);
    check("credit8", credit, 8);
    check("credit8_lights", item_light, 4'b0011);
    push(EV_CO, 8);
    press(0, 0, 4'b0001, 1, 0);
    ticks(10);
    check("cancel_buy_credit", credit, 0);

    // simultaneous buys: lowest index (1, price 8) wins over 2
    tens(1);
    ones(3);
    push(ev_vend(1), 1);
    press(0, 0, 4'b0110, 0, 0);
    check("lowest_idx_credit", credit, 5);
    // get_ind beats coin in the same cycle: coin dropped
    push(EV_CO, 5);
    press(0, 1, '0, 0, 1);
    ticks(8);
    check("get_beats_coin_credit", credit, 0);

    // reset in the middle of change return
    tens(2);
    push(EV_CT, 1);
    press(0, 0, '0, 0, 1);
    check("mid_change_credit", credit, 10);
    reset = 1;
    #1;
    check("abort_credit", credit, 0);
    check("abort_light", light_get, 0);
    check("abort_change_ten", change_ten, 0);
    ticks(2);
    reset = 0;
    ticks(3);
    check("abort_op_start", op_start, 0);

    // inactivity behaviour
    ones(1);
`ifdef INACTIVITY_TIMEOUT_EN
    exp_q.push_back(EV_CO);
    ticks(30);
    check("timeout_credit", credit, 0);
    check("timeout_op_start", op_start, 0);
`else
    ticks(30);
    check("no_timeout_credit", credit, 1);
    check("no_timeout_op_start", op_start, 1);
    push(EV_CO, 1);
    press(0, 0, '0, 1, 0);
    ticks(4);
    check("no_timeout_refund", credit, 0);
`endif

    ticks(2);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
